// File: rtl/fifo_pop_ctrl.sv
// Read-side controller for the team fifo: issues rd_en, captures the registered
// fifo output into a 2-entry buffer and hands words downstream on valid/ready.
module fifo_pop_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [CNT_WIDTH-1:0]  pop_count,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  pop, cap;
  logic [2:0]            pending;
  logic [1:0]            wr_idx;

  always_comb begin
    pop     = (occ_q != 2'd0) & ready_in;
    cap     = inflight_q;
    // Words held or on their way once this cycle's pop leaves; never exceed 2.
    pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en = !rst && (state_q == ACTIVE) && !fifo_empty && (pending < 3'd2);
    inflight_d = fifo_rd_en;

    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = ACTIVE;
      ACTIVE:  if (!enable) state_d = FLUSH;
      FLUSH:   if ((occ_q == 2'd0) && !inflight_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    occ_d  = occ_q + {1'b0, cap} - {1'b0, pop};
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop && (occ_q == 2'd2)) buf0_d = buf1_q;
    // Capture lands in the slot that is free after the pop shifts the head.
    wr_idx = occ_q - {1'b0, pop};
    if (cap) begin
      if (wr_idx == 2'd0) buf0_d = fifo_data;
      else                buf1_d = fifo_data;
    end

    cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(cap && (occ_q == 2'd2) && !pop));
  end

  assign data_out  = buf0_q;
  assign valid_out = (occ_q != 2'd0);
  assign pop_count = cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Bench for fifo_pop_ctrl: fifo model, scoreboard of written words, directed
// scenarios followed by randomized enable/ready/write traffic.
module tb_fifo_pop_ctrl;
  localparam int DW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          ready_in = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en, valid_out, busy;
  logic [DW-1:0] data_out;
  logic [CW-1:0] pop_count;

  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          fifo_clr = 1'b0;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] exp_cnt = '0;
  int            rd_cnt = 0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  fifo_pop_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .data_out(data_out),
    .valid_out(valid_out), .ready_in(ready_in), .pop_count(pop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered-output fifo: word appears on fifo_data the cycle after a read.
  always @(posedge clk) begin
    if (fifo_clr) fifo_q.delete();
    else begin
      if (fifo_rd_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
      if (wr_en) fifo_q.push_back(wr_data);
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      chk("pop_count", pop_count, exp_cnt);
      if (rst) begin
        chk("rd_en_in_rst", fifo_rd_en, 0);
        exp_cnt   = '0;
        prev_hold = 1'b0;
      end else begin
        if (fifo_rd_en) begin
          rd_cnt++;
          chk("rd_on_empty", fifo_empty, 0);
        end
        if (prev_hold) begin
          chk("hold_valid", valid_out, 1);
          chk("hold_data", data_out, prev_data);
        end
        if (valid_out && ready_in) begin
          if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
          else chk("data_order", data_out, exp_q.pop_front());
          exp_cnt++;
        end
        prev_hold = valid_out && !ready_in;
        prev_data = data_out;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] w);
    wr_en = 1'b1;
    wr_data = w;
    exp_q.push_back(w);
    step();
    wr_en = 1'b0;
  endtask

  task automatic finish_reset();
    fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
    exp_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0]    rd_pat;
    logic [7:0]    vld_pat;
    logic [DW-1:0] first_w;
    int            r0;
    int            guard;

    fork
      monitor();
    join_none

    // Reset with a non-empty fifo and enable high.
    rst = 1'b1; enable = 1'b1; ready_in = 1'b1;
    step();
    write_word(4'h9); write_word(4'h5); write_word(4'h2);
    repeat (2) begin
      @(negedge clk);
      chk("rst_fifo_rd_en", fifo_rd_en, 0);
      step();
    end
    @(negedge clk);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_pop_count", pop_count, 0);
    chk("rst_busy", busy, 0);
    step();
    enable = 1'b0;
    finish_reset();

    // Streaming 3,7,A,F.
    write_word(4'h3); write_word(4'h7); write_word(4'hA); write_word(4'hF);
    step();
    enable = 1'b1;
    rd_pat  = 8'b0001_1110;
    vld_pat = 8'b0111_1000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("stream_rd_en", fifo_rd_en, rd_pat[c]);
      chk("stream_valid", valid_out, vld_pat[c]);
      step();
    end
    chk("stream_count", pop_count, 4);

    // Backpressure: only two reads may be outstanding.
    ready_in = 1'b0;
    r0 = rd_cnt;
    first_w = 4'($urandom_range(0, 15));
    write_word(first_w);
    for (int i = 0; i < 4; i++) write_word(4'($urandom_range(0, 15)));
    repeat (8) step();
    chk("bp_reads", rd_cnt - r0, 2);
    @(negedge clk);
    chk("bp_rd_en_low", fifo_rd_en, 0);
    chk("bp_valid", valid_out, 1);
    chk("bp_head", data_out, first_w);
    step();
    ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_release_rate", valid_out, 1);
      step();
    end
    repeat (3) step();
    chk("bp_count", pop_count, 9);

    // Empty boundary: long idle, then a single word.
    r0 = rd_cnt;
    repeat (10) step();
    chk("empty_no_reads", rd_cnt - r0, 0);
    write_word(4'h6);
    repeat (6) step();
    chk("empty_one_read", rd_cnt - r0, 1);
    chk("empty_count", pop_count, 10);

    // Flush: enable dropped while the second read is issued.
    enable = 1'b0;
    repeat (5) step();
    write_word(4'h1); write_word(4'h2); write_word(4'h4); write_word(4'h8);
    step();
    r0 = rd_cnt;
    enable = 1'b1;
    step();
    step();
    enable = 1'b0;
    for (int c = 2; c < 9; c++) begin
      @(negedge clk);
      if (c >= 3) chk("flush_no_rd", fifo_rd_en, 0);
      if (c == 4) chk("flush_busy_high", busy, 1);
      if (c == 6) chk("flush_busy_low", busy, 0);
      step();
    end
    chk("flush_reads", rd_cnt - r0, 2);
    chk("flush_count", pop_count, 12);

    // Counter wrap after a fresh reset.
    rst = 1'b1;
    step();
    finish_reset();
    enable = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 17; i++) write_word(4'($urandom_range(0, 15)));
    repeat (6) step();
    chk("wrap_count", pop_count, 1);

    // Reset with a full buffer drops everything.
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) write_word(4'($urandom_range(0, 15)));
    repeat (4) step();
    @(negedge clk);
    chk("midrst_pre_valid", valid_out, 1);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("midrst_valid", valid_out, 0);
    step();
    finish_reset();
    ready_in = 1'b1;
    repeat (8) step();
    chk("midrst_count", pop_count, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      wr_en = ($urandom_range(0, 1) == 1);
      if (wr_en) begin
        wr_data = 4'($urandom_range(0, 15));
        exp_q.push_back(wr_data);
      end
      ready_in = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      step();
    end
    wr_en = 1'b0; enable = 1'b1; ready_in = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 500) begin
      step();
      guard++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
